memory_responder: RTL

Memory-side responder for the execution unit's split read/write RAM interface. It owns the byte-wide program/data memory, services core reads and writes, and maps one address to an I/O register pair. After reset it first runs a streaming program loader, holding the core in reset until the image is in memory.

---
 rtl/memory_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Byte-wide program/data memory responder: streaming loader after reset, then
// zero-latency core reads, clocked core writes and one memory-mapped I/O register pair.
module memory_responder #(
    parameter int                   ADDR_BITS = 8,
    parameter int                   DATA_BITS = 8,
    parameter logic [ADDR_BITS-1:0] IO_ADDR   = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_ram_en,
    input  logic [ADDR_BITS-1:0] rd_ram_addr,
    output logic [DATA_BITS-1:0] rd_ram_data,
    input  logic                 wr_ram_en,
    input  logic [ADDR_BITS-1:0] wr_ram_addr,
    input  logic [DATA_BITS-1:0] wr_ram_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [DATA_BITS-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 core_reset,
    input  logic [DATA_BITS-1:0] io_in,
    output logic [DATA_BITS-1:0] io_out
);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ADDR_BITS-1:0]   load_ptr_r;
    logic [DATA_BITS-1:0]   io_out_r;
    logic [DATA_BITS-1:0]   rd_hold_r;
    logic                   core_reset_r;
    logic [DATA_BITS-1:0]   mem_r [DEPTH];

    logic                   ld_ready_s;
    logic                   accept_s;
    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_waddr_s;
    logic [DATA_BITS-1:0]   mem_wdata_s;
    logic                   io_we_s;
    logic                   rd_active_s;
    logic [DATA_BITS-1:0]   rd_val_s;
    logic [DATA_BITS-1:0]   rd_data_s;

    // Next-state, shared memory write port and read-data selection
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = load_ptr_r;
        mem_wdata_s  = ld_data;
        io_we_s      = 1'b0;
        ld_ready_s   = (state_r == LOAD) && !reset;
        rd_active_s  = (state_r == RUN) && rd_ram_en && !reset;

        if (rd_ram_addr == IO_ADDR) begin
            rd_val_s = io_in;
        end else begin
            rd_val_s = mem_r[rd_ram_addr];
        end

        case (state_r)
            LOAD: begin
                if (ld_valid && ld_ready_s) begin
                    accept_s = 1'b1;
                    mem_we_s = 1'b1;
                    // Last marker or the top byte (memory full) ends the load
                    if (ld_last || (&load_ptr_r)) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            RUN: begin
                state_next_s = RUN;
                if (wr_ram_en && !reset) begin
                    mem_waddr_s = wr_ram_addr;
                    mem_wdata_s = wr_ram_data;
                    if (wr_ram_addr == IO_ADDR) begin
                        io_we_s = 1'b1;
                    end else begin
                        mem_we_s = 1'b1;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_next_s = LOAD;
            end
        endcase

        if (reset) begin
            rd_data_s = '0;
        end else if (rd_active_s) begin
            rd_data_s = rd_val_s;
        end else begin
            rd_data_s = rd_hold_r;
        end
    end

    // Control state, load pointer, I/O register and read hold register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LOAD;
            load_ptr_r   <= '0;
            io_out_r     <= '0;
            rd_hold_r    <= '0;
            core_reset_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            core_reset_r <= (state_next_s == LOAD);
            if (accept_s) begin
                load_ptr_r <= load_ptr_r + ADDR_BITS'(1);
            end
            if (io_we_s) begin
                io_out_r <= wr_ram_data;
            end
            if (rd_active_s) begin
                rd_hold_r <= rd_val_s;
            end
        end
    end

    // Memory array is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign ld_ready    = ld_ready_s;
    assign core_reset  = core_reset_r;
    assign io_out      = io_out_r;
    assign rd_ram_data = rd_data_s;

endmodule
